// File: rtl/frame_sample_tx_pkg.sv
// rtl/frame_sample_tx_pkg.sv - shared types and constants for the frame sample transmitter
package frame_sample_tx_pkg;

  // Defaults shared with the capture block on the far side of the link
  localparam int DATA_SIZE_DEF   = 4;
  localparam int LENGTH_DEF      = 64;
  localparam int LENGTH_SIZE_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } txState_t;

  localparam logic [1:0] MODE_BUF   = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: shift left, feedback parity enters at bit 0
  function automatic logic [7:0] lfsrNext(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/frame_sample_buf.sv
// rtl/frame_sample_buf.sv - frame sample buffer, sync write port and registered read port
module frame_sample_buf #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH      = 64,
  parameter int LENGTH_SIZE = 6
) (
  input  logic                   clk200,
  input  logic                   wrEn,
  input  logic [LENGTH_SIZE-1:0] wrAdd,
  input  logic [DATA_SIZE-1:0]   wrData,
  input  logic [LENGTH_SIZE-1:0] rdAdd,
  output logic [DATA_SIZE-1:0]   rdData
);

  logic [DATA_SIZE-1:0] mem [LENGTH];

  // Write port
  always_ff @(posedge clk200) begin
    if (wrEn) mem[wrAdd] <= wrData;
  end

  // Registered read; a same-address write is forwarded so a write issued with Start is seen by beat 0
  always_ff @(posedge clk200) begin
    if (wrEn && (wrAdd == rdAdd)) rdData <= wrData;
    else                          rdData <= mem[rdAdd];
  end

endmodule

// File: rtl/frame_sample_tx.sv
// rtl/frame_sample_tx.sv - framed sample burst generator feeding the histogram capture block
module frame_sample_tx
  import frame_sample_tx_pkg::*;
#(
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int LENGTH      = LENGTH_DEF,
  parameter int LENGTH_SIZE = LENGTH_SIZE_DEF,
  parameter int PRE_CYCLES  = 2,
  parameter int GAP_CYCLES  = 128
) (
  input  logic                   clk200,
  input  logic                   rstn,
  input  logic                   WrEn,
  input  logic [LENGTH_SIZE-1:0] WrAdd,
  input  logic [DATA_SIZE-1:0]   WrData,
  input  logic [1:0]             Mode,
  input  logic [3:0]             IdleEvery,
  input  logic                   Start,
  output logic                   Busy,
  output logic                   FrameDone,
  output logic                   Collect,
  output logic                   Valid,
  output logic [DATA_SIZE-1:0]   Data,
  output logic [LENGTH_SIZE:0]   SentCount
);

  localparam int CNT_MAX = (GAP_CYCLES > PRE_CYCLES) ? GAP_CYCLES : PRE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [LENGTH_SIZE:0] LAST_COUNT = (LENGTH_SIZE+1)'(LENGTH);

  txState_t               state;
  logic [CNT_W-1:0]       waitCnt;
  logic [3:0]             runCnt;
  logic [1:0]             modeLat;
  logic [3:0]             idleLat;
  logic [DATA_SIZE-1:0]   constLat;
  logic [7:0]             lfsr;
  logic [DATA_SIZE-1:0]   bufData;
  logic [LENGTH_SIZE-1:0] rdAdd;
  logic [LENGTH_SIZE-1:0] beatIdx;
  logic [DATA_SIZE-1:0]   beatValue;
  logic                   bufWrEn;
  logic                   emitValid;

  // SentCount doubles as the index of the next sample to send
  assign beatIdx = SentCount[LENGTH_SIZE-1:0];

  // The buffer is frozen for the whole frame and guard gap
  assign bufWrEn = WrEn && (state == ST_IDLE);

  frame_sample_buf #(
    .DATA_SIZE   (DATA_SIZE),
    .LENGTH      (LENGTH),
    .LENGTH_SIZE (LENGTH_SIZE)
  ) u_buf (
    .clk200 (clk200),
    .wrEn   (bufWrEn),
    .wrAdd  (WrAdd),
    .wrData (WrData),
    .rdAdd  (rdAdd),
    .rdData (bufData)
  );

  // Decide whether this edge launches a valid beat: end of PRE, or SEND when neither finished nor owing an idle beat
  always_comb begin
    emitValid = 1'b0;
    if (state == ST_PRE) begin
      emitValid = (waitCnt == '0);
    end else if (state == ST_SEND) begin
      emitValid = (SentCount != LAST_COUNT) && !((idleLat != 4'd0) && (runCnt == idleLat));
    end
  end

  // Read address runs one beat ahead: it is the index current after this edge, so bufData is ready when that beat goes out
  always_comb begin
    rdAdd = beatIdx;
    if (state == ST_IDLE) rdAdd = '0;
    else if (emitValid)   rdAdd = beatIdx + 1'b1;
  end

  // Sample value for the beat about to be launched, chosen by the mode latched at Start
  always_comb begin
    beatValue = bufData;
    case (modeLat)
      MODE_RAMP:  beatValue = DATA_SIZE'(beatIdx);
      MODE_LFSR:  beatValue = DATA_SIZE'(lfsr);
      MODE_CONST: beatValue = constLat;
      default:    beatValue = bufData;
    endcase
  end

  // Frame sequencer with registered outputs; beat launch is shared between the last PRE cycle and SEND
  always_ff @(posedge clk200 or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      waitCnt   <= '0;
      runCnt    <= '0;
      modeLat   <= MODE_BUF;
      idleLat   <= '0;
      constLat  <= '0;
      lfsr      <= LFSR_SEED;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
      Collect   <= 1'b0;
      Valid     <= 1'b0;
      Data      <= '0;
      SentCount <= '0;
    end else begin
      FrameDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state     <= ST_PRE;
            Busy      <= 1'b1;
            Collect   <= 1'b1;
            waitCnt   <= CNT_W'(PRE_CYCLES - 1);
            runCnt    <= '0;
            modeLat   <= Mode;
            idleLat   <= IdleEvery;
            constLat  <= WrData;
            lfsr      <= LFSR_SEED;
            SentCount <= '0;
          end
        end
        ST_PRE: begin
          if (waitCnt != '0) waitCnt <= waitCnt - 1'b1;
          else               state   <= ST_SEND;
        end
        ST_SEND: begin
          if (SentCount == LAST_COUNT) begin
            state     <= ST_GAP;
            Collect   <= 1'b0;
            FrameDone <= 1'b1;
            waitCnt   <= CNT_W'(GAP_CYCLES - 1);
          end
        end
        default: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
          end else begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
      endcase

      if (emitValid) begin
        Valid     <= 1'b1;
        Data      <= beatValue;
        SentCount <= SentCount + 1'b1;
        runCnt    <= runCnt + 1'b1;
        lfsr      <= lfsrNext(lfsr);
      end else if (state == ST_SEND) begin
        Valid <= 1'b0;
        if (SentCount != LAST_COUNT) runCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_sample_tx.sv
// tb/tb_frame_sample_tx.sv - directed self-checking bench for frame_sample_tx
module tb_frame_sample_tx;
  import frame_sample_tx_pkg::*;

  localparam int DW  = 4;
  localparam int LEN = 64;
  localparam int LW  = 6;
  localparam int PRE = 2;
  localparam int GAP = 128;

  logic          clk200 = 1'b0;
  logic          rstn = 1'b0;
  logic          WrEn = 1'b0;
  logic [LW-1:0] WrAdd = '0;
  logic [DW-1:0] WrData = '0;
  logic [1:0]    Mode = '0;
  logic [3:0]    IdleEvery = '0;
  logic          Start = 1'b0;
  logic          Busy, FrameDone, Collect, Valid;
  logic [DW-1:0] Data;
  logic [LW:0]   SentCount;

  always #5 clk200 = ~clk200;

  frame_sample_tx #(
    .DATA_SIZE (DW), .LENGTH (LEN), .LENGTH_SIZE (LW),
    .PRE_CYCLES (PRE), .GAP_CYCLES (GAP)
  ) dut (
    .clk200 (clk200), .rstn (rstn), .WrEn (WrEn), .WrAdd (WrAdd), .WrData (WrData),
    .Mode (Mode), .IdleEvery (IdleEvery), .Start (Start), .Busy (Busy),
    .FrameDone (FrameDone), .Collect (Collect), .Valid (Valid), .Data (Data),
    .SentCount (SentCount)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] bufModel [LEN];
  logic [DW-1:0] capData [128];
  logic [DW-1:0] lfsrRef [LEN];
  int nValid, firstValid, collectCycles, doneAt, busyLowAt, idleBeats, runBad, runLen;
  logic doneCollect, doneValid, collectFirst, busyFirst;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk200);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [3:0] ie, input logic [DW-1:0] wd, input logic we);
    Mode = m; IdleEvery = ie; WrData = wd; WrAdd = '0; WrEn = we; Start = 1'b1;
    tick();
    Start = 1'b0; WrEn = 1'b0;
  endtask

  // Record the frame from cycle t+1 until Busy drops after FrameDone; rel counts cycles after the Start edge
  task automatic capture(input int idleExp, input int injA, input int injB, input int injWr, input logic hold);
    int rel;
    nValid = 0; firstValid = -1; collectCycles = 0; doneAt = -1; busyLowAt = -1;
    idleBeats = 0; runBad = 0; runLen = 0; doneCollect = 1'bx; doneValid = 1'bx;
    collectFirst = Collect; busyFirst = Busy;
    rel = 1;
    while (rel < 600) begin
      if (Collect) collectCycles++;
      if (Valid) begin
        if (nValid == 0) firstValid = rel;
        if (nValid < 128) capData[nValid] = Data;
        nValid++;
        runLen++;
      end else if (Collect && nValid > 0) begin
        idleBeats++;
        if (runLen != idleExp) runBad++;
        runLen = 0;
      end
      if (FrameDone) begin
        doneAt = rel; doneCollect = Collect; doneValid = Valid;
      end
      if (doneAt > 0 && !Busy) begin
        busyLowAt = rel;
        break;
      end
      Start = hold || (rel == injA) || (rel == injB);
      WrEn = (rel == injWr);
      if (rel == injWr) begin WrAdd = '0; WrData = 4'hF; end
      tick();
      rel++;
    end
    WrEn = 1'b0;
    checkEq("frame_end_seen", busyLowAt > 0, 1);
  endtask

  initial begin
    int bad;

    // Reset state
    tick(); tick();
    checkEq("rst_busy", Busy, 0);
    checkEq("rst_framedone", FrameDone, 0);
    checkEq("rst_collect", Collect, 0);
    checkEq("rst_valid", Valid, 0);
    checkEq("rst_data", Data, 0);
    checkEq("rst_sentcount", SentCount, 0);
    rstn = 1'b1;
    tick();

    // Fill the buffer with k^5
    for (int k = 0; k < LEN; k++) begin
      WrEn = 1'b1; WrAdd = LW'(k); WrData = DW'(k ^ 5); bufModel[k] = DW'(k ^ 5);
      tick();
    end
    WrEn = 1'b0;
    tick();

    // Mode 0 timing and contents
    launch(MODE_BUF, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 0, 1'b0);
    checkEq("m0_collect_t1", collectFirst, 1);
    checkEq("m0_busy_t1", busyFirst, 1);
    checkEq("m0_first_valid", firstValid, 3);
    checkEq("m0_collect_len", collectCycles, PRE + LEN);
    checkEq("m0_done_at", doneAt, 67);
    checkEq("m0_done_collect", doneCollect, 0);
    checkEq("m0_done_valid", doneValid, 0);
    checkEq("m0_busy_low_at", busyLowAt, 67 + GAP);
    checkEq("m0_nvalid", nValid, LEN);
    checkEq("m0_sentcount", SentCount, LEN);
    for (int k = 0; k < LEN; k++) checkEq($sformatf("m0_beat%0d", k), capData[k], bufModel[k]);

    // Mode 1 with an idle beat after every 4 valid beats
    launch(MODE_RAMP, 4'd4, '0, 1'b0);
    capture(4, 0, 0, 0, 1'b0);
    checkEq("ramp_collect_len", collectCycles, 81);
    checkEq("ramp_done_at", doneAt, 82);
    checkEq("ramp_idle_beats", idleBeats, 15);
    checkEq("ramp_run_bad", runBad, 0);
    checkEq("ramp_nvalid", nValid, LEN);
    checkEq("ramp_sentcount", SentCount, LEN);
    bad = 0;
    for (int k = 0; k < LEN; k++) if (capData[k] !== DW'(k % 16)) bad++;
    checkEq("ramp_data_bad", bad, 0);

    // Mode 2 LFSR sequence and its repeatability
    launch(MODE_LFSR, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 0, 1'b0);
    checkEq("lfsr_b0", capData[0], 4'h1);
    checkEq("lfsr_b1", capData[1], 4'h2);
    checkEq("lfsr_b2", capData[2], 4'h4);
    checkEq("lfsr_b3", capData[3], 4'h8);
    checkEq("lfsr_b4", capData[4], 4'h1);
    checkEq("lfsr_b5", capData[5], 4'h3);
    checkEq("lfsr_b6", capData[6], 4'h7);
    checkEq("lfsr_b7", capData[7], 4'hE);
    for (int k = 0; k < LEN; k++) lfsrRef[k] = capData[k];
    launch(MODE_LFSR, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < LEN; k++) if (capData[k] !== lfsrRef[k]) bad++;
    checkEq("lfsr_repeat_bad", bad, 0);
    checkEq("lfsr_repeat_nvalid", nValid, LEN);

    // Start pulses during SEND and GAP are ignored
    launch(MODE_RAMP, 4'd0, '0, 1'b0);
    capture(0, 20, 100, 0, 1'b0);
    checkEq("ign_nvalid", nValid, LEN);
    checkEq("ign_done_at", doneAt, 67);
    checkEq("ign_busy_low_at", busyLowAt, 67 + GAP);
    tick();
    checkEq("ign_no_relaunch_collect", Collect, 0);
    checkEq("ign_no_relaunch_busy", Busy, 0);

    // Start held high relaunches right after the guard gap
    Start = 1'b1;
    launch(MODE_RAMP, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 0, 1'b1);
    tick();
    checkEq("hold_relaunch_collect", Collect, 1);
    checkEq("hold_gap_len", busyLowAt - doneAt, GAP);
    Start = 1'b0;
    for (int i = 0; i < 400 && Busy; i++) tick();
    checkEq("hold_drain_busy", Busy, 0);

    // WrEn while Busy is ignored
    launch(MODE_BUF, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 10, 1'b0);
    launch(MODE_BUF, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 0, 1'b0);
    checkEq("wr_busy_beat0", capData[0], bufModel[0]);

    // WrEn together with Start lands in this frame
    launch(MODE_BUF, 4'd0, 4'hF, 1'b1);
    bufModel[0] = 4'hF;
    capture(0, 0, 0, 0, 1'b0);
    checkEq("wr_start_beat0", capData[0], 4'hF);
    checkEq("wr_start_beat1", capData[1], bufModel[1]);

    // Mode 3 constant
    launch(MODE_CONST, 4'd0, 4'hA, 1'b0);
    capture(0, 0, 0, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < LEN; k++) if (capData[k] !== 4'hA) bad++;
    checkEq("const_data_bad", bad, 0);
    checkEq("const_nvalid", nValid, LEN);

    // Reset in the middle of a frame
    launch(MODE_BUF, 4'd0, '0, 1'b0);
    for (int i = 0; i < 32; i++) tick();
    checkEq("mid_valid_b30", Valid, 1);
    checkEq("mid_data_b30", Data, bufModel[30]);
    #1 rstn = 1'b0;
    #1;
    checkEq("mid_rst_collect", Collect, 0);
    checkEq("mid_rst_valid", Valid, 0);
    checkEq("mid_rst_busy", Busy, 0);
    tick();
    checkEq("mid_rst_framedone", FrameDone, 0);
    rstn = 1'b1;
    tick();
    checkEq("post_rst_framedone", FrameDone, 0);
    checkEq("post_rst_sentcount", SentCount, 0);
    launch(MODE_BUF, 4'd0, '0, 1'b0);
    capture(0, 0, 0, 0, 1'b0);
    checkEq("post_rst_nvalid", nValid, LEN);
    checkEq("post_rst_sentcount_end", SentCount, LEN);
    bad = 0;
    for (int k = 0; k < LEN; k++) if (capData[k] !== bufModel[k]) bad++;
    checkEq("post_rst_data_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
